// File: rtl/alu_pipe_stage.sv
// Two-operand join stage with a registered 2-bit-opcode ALU and valid/stall handshake.
// Define ALU_PIPE_FLAGS_EN to add registered zero_o/carry_o flag outputs.
module alu_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i1,
    input  logic [WIDTH-1:0] data_i1,
    input  logic             v_i2,
    input  logic [WIDTH-1:0] data_i2,
    input  logic [1:0]       opcode,
    input  logic             stall_i,
    output logic             v_o,
    output logic [WIDTH-1:0] data_o,
`ifdef ALU_PIPE_FLAGS_EN
    output logic             zero_o,
    output logic             carry_o,
`endif
    output logic             stall_o1,
    output logic             stall_o2
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    logic             hold;
    logic             fire;
    logic [WIDTH:0]   alu_wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    logic             v_d;
    logic             v_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // A full output that downstream refuses is frozen; an empty stage always accepts.
    assign hold     = v_q & stall_i;
    assign fire     = v_i1 & v_i2 & ~hold;
    assign stall_o1 = hold | (v_i1 & ~v_i2);
    assign stall_o2 = hold | (v_i2 & ~v_i1);

    // Extra MSB carries add carry-out, or the borrow (A<B) of a subtraction.
    always_comb begin
        alu_wide = '0;
        unique case (alu_op_e'(opcode))
            OP_ADD:  alu_wide = {1'b0, data_i1} + {1'b0, data_i2};
            OP_SUB:  alu_wide = {1'b0, data_i1} - {1'b0, data_i2};
            OP_AND:  alu_wide = {1'b0, data_i1 & data_i2};
            OP_OR:   alu_wide = {1'b0, data_i1 | data_i2};
            default: alu_wide = '0;
        endcase
    end

    assign alu_res   = alu_wide[WIDTH-1:0];
    assign alu_carry = alu_wide[WIDTH];

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (!hold) begin
            v_d = v_i1 & v_i2;
            if (fire) begin
                data_d = alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

`ifdef ALU_PIPE_FLAGS_EN
    logic zero_d;
    logic zero_q;
    logic carry_d;
    logic carry_q;

    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (fire) begin
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero_o  = zero_q;
    assign carry_o = carry_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Scoreboard bench for alu_pipe_stage: expected results are queued at issue and
// compared when the stage presents them. Flag checks follow ALU_PIPE_FLAGS_EN.
module tb_alu_pipe_stage;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             carry;
    } result_t;

    logic             clk;
    logic             reset;
    logic             v_i1;
    logic [WIDTH-1:0] data_i1;
    logic             v_i2;
    logic [WIDTH-1:0] data_i2;
    logic [1:0]       opcode;
    logic             stall_i;
    logic             v_o;
    logic [WIDTH-1:0] data_o;
    logic             stall_o1;
    logic             stall_o2;
`ifdef ALU_PIPE_FLAGS_EN
    logic             zero_o;
    logic             carry_o;
`endif

    int checks;
    int failures;

    result_t scoreboard[$];
    result_t last_res;

    alu_pipe_stage #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .v_i1     (v_i1),
        .data_i1  (data_i1),
        .v_i2     (v_i2),
        .data_i2  (data_i2),
        .opcode   (opcode),
        .stall_i  (stall_i),
        .v_o      (v_o),
        .data_o   (data_o),
`ifdef ALU_PIPE_FLAGS_EN
        .zero_o   (zero_o),
        .carry_o  (carry_o),
`endif
        .stall_o1 (stall_o1),
        .stall_o2 (stall_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic result_t ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic [1:0] op);
        result_t r;
        logic [WIDTH-1:0] res;
        logic c;
        c = 1'b0;
        case (op)
            2'b00: begin
                res = a + b;
                c   = (res < a);
            end
            2'b01: begin
                res = a - b;
                c   = (a < b);
            end
            2'b10:   res = a & b;
            default: res = a | b;
        endcase
        r.data  = res;
        r.zero  = (res == 0);
        r.carry = c;
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        logic    exp_v;
        result_t cur;
        exp_v = (scoreboard.size() != 0);
        cur   = exp_v ? scoreboard[0] : last_res;
        chk({tag, ".v_o"}, 64'(v_o), 64'(exp_v));
        chk({tag, ".data_o"}, 64'(data_o), 64'(cur.data));
`ifdef ALU_PIPE_FLAGS_EN
        chk({tag, ".zero_o"}, 64'(zero_o), 64'(cur.zero));
        chk({tag, ".carry_o"}, 64'(carry_o), 64'(cur.carry));
`endif
    endtask

    // Called on a falling edge: checks the previous edge's result, drives new
    // inputs, checks the combinational stalls, then advances the model.
    task automatic step(input string tag, input logic v1, input logic [WIDTH-1:0] a,
                        input logic v2, input logic [WIDTH-1:0] b,
                        input logic [1:0] op, input logic st);
        logic hold;
        check_outputs(tag);
        v_i1    = v1;
        data_i1 = a;
        v_i2    = v2;
        data_i2 = b;
        opcode  = op;
        stall_i = st;
        #1;
        hold = (scoreboard.size() != 0) && st;
        chk({tag, ".stall_o1"}, 64'(stall_o1), 64'(hold | (v1 & ~v2)));
        chk({tag, ".stall_o2"}, 64'(stall_o2), 64'(hold | (v2 & ~v1)));
        if (!hold) begin
            if (scoreboard.size() != 0) last_res = scoreboard.pop_front();
            if (v1 && v2) scoreboard.push_back(ref_alu(a, b, op));
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_res = '{data: '0, zero: 1'b0, carry: 1'b0};
        reset    = 1'b0;
        v_i1     = 1'b0;
        data_i1  = '0;
        v_i2     = 1'b0;
        data_i2  = '0;
        opcode   = 2'b00;
        stall_i  = 1'b0;

        // Reset held low for two cycles.
        repeat (2) @(negedge clk);
        check_outputs("reset");
        chk("reset.stall_o1", 64'(stall_o1), 64'(0));
        chk("reset.stall_o2", 64'(stall_o2), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back issue of all four ops with A=5, B=3.
        step("add", 1'b1, 32'd5, 1'b1, 32'd3, 2'b00, 1'b0);
        step("sub", 1'b1, 32'd5, 1'b1, 32'd3, 2'b01, 1'b0);
        step("and", 1'b1, 32'd5, 1'b1, 32'd3, 2'b10, 1'b0);
        step("or",  1'b1, 32'd5, 1'b1, 32'd3, 2'b11, 1'b0);
        step("drain", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);
        step("idle", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);

        // Downstream stall holds a valid result and back-pressures both producers.
        step("pre_hold", 1'b1, 32'd10, 1'b1, 32'd20, 2'b00, 1'b0);
        step("hold1", 1'b1, 32'h0F0, 1'b1, 32'h00F, 2'b11, 1'b1);
        step("hold2", 1'b1, 32'h0F0, 1'b1, 32'h00F, 2'b11, 1'b1);
        step("release", 1'b1, 32'h0F0, 1'b1, 32'h00F, 2'b11, 1'b0);
        step("post_hold", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);

        // Lone operand waits for its partner; then the B-only case.
        step("lone_a", 1'b1, 32'd9, 1'b0, 32'd0, 2'b01, 1'b0);
        step("pair", 1'b1, 32'd9, 1'b1, 32'd4, 2'b01, 1'b0);
        step("lone_b", 1'b0, 32'd0, 1'b1, 32'd6, 2'b00, 1'b0);
        step("pair_b", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);

        // stall_i with an empty stage must not block acceptance.
        step("empty_stall", 1'b1, 32'd2, 1'b1, 32'd2, 2'b00, 1'b1);
        step("empty_stall_out", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);

        // Wrapping subtract, zero result, and add carry-out.
        step("wrap_sub", 1'b1, 32'd3, 1'b1, 32'd5, 2'b01, 1'b0);
        step("zero_and", 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h5555_5555, 2'b10, 1'b0);
        step("carry_add", 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd2, 2'b00, 1'b0);
        step("after_carry", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);

        // Asynchronous reset while a result is valid.
        step("pre_reset", 1'b1, 32'd7, 1'b1, 32'd7, 2'b00, 1'b0);
        check_outputs("valid_before_reset");
        v_i1 = 1'b0;
        v_i2 = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        scoreboard.delete();
        last_res = '{data: '0, zero: 1'b0, carry: 1'b0};
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        step("after_reset", 1'b1, 32'd1, 1'b1, 32'd1, 2'b00, 1'b0);
        step("final", 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
